// File: rtl/block_serial_csa_adder_pkg.sv
// Shared types and sizing helpers for the block-serial carry-skip adder.
package csa_pkg;

    localparam int unsigned DEFAULT_BLOCK_SIZE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of BLOCK_SIZE-bit slices in an N-bit operand; never returns 0.
    function automatic int unsigned num_blocks(input int unsigned n, input int unsigned block_size);
        int unsigned nb;
        nb = (block_size == 0) ? 1 : (n / block_size);
        return (nb == 0) ? 1 : nb;
    endfunction

endpackage

// File: rtl/block_serial_csa_adder_csb.sv
// Combinational carry-skip slice: ripple adder with a bypass mux on the carry-out.
module carry_skip_block #(
    parameter int unsigned BLOCK_SIZE = 4
) (
    input  logic [BLOCK_SIZE-1:0] a_slice,
    input  logic [BLOCK_SIZE-1:0] b_slice,
    input  logic                  cin,
    output logic [BLOCK_SIZE-1:0] s_slice,
    output logic                  cout
);

    logic [BLOCK_SIZE-1:0] p;
    logic                  c;

    always_comb begin
        p       = a_slice ^ b_slice;
        c       = cin;
        s_slice = '0;
        for (int i = 0; i < int'(BLOCK_SIZE); i++) begin
            s_slice[i] = p[i] ^ c;
            c          = (a_slice[i] & b_slice[i]) | (p[i] & c);
        end
        // Full propagate: the carry-in passes straight through.
        cout = (&p) ? cin : c;
    end

endmodule

// File: rtl/block_serial_csa_adder.sv
// Block-serial N-bit adder: one carry-skip slice per cycle, valid/ready on both sides.
// Optional early completion on zero upper operand bits: define CSA_EARLY_DONE_EN.
module block_serial_csa_adder
    import csa_pkg::*;
#(
    parameter int unsigned N          = 16,
    parameter int unsigned BLOCK_SIZE = DEFAULT_BLOCK_SIZE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int unsigned NUM_BLOCKS = num_blocks(N, BLOCK_SIZE);
    localparam int unsigned IDX_W      = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_BLOCKS - 1);
    localparam logic [N-1:0]     SLICE_MASK = N'({BLOCK_SIZE{1'b1}});

    generate
        if ((BLOCK_SIZE == 0) || ((N % BLOCK_SIZE) != 0)) begin : g_bad_cfg
            $error("block_serial_csa_adder: N must be a non-zero multiple of BLOCK_SIZE");
        end
    endgenerate

    state_t           state, state_d;
    logic [IDX_W-1:0] blk_idx, blk_idx_d;
    logic             carry, carry_d;
    logic [N-1:0]     a_q, a_d, b_q, b_d;
    logic [N-1:0]     sum_d;
    logic             cout_d, out_valid_d, in_ready_d;

    logic [31:0]           base;
    logic [BLOCK_SIZE-1:0] a_slice, b_slice, s_slice;
    logic                  blk_cout;

    always_comb begin
        base    = 32'(blk_idx) * BLOCK_SIZE;
        a_slice = BLOCK_SIZE'(a_q >> base);
        b_slice = BLOCK_SIZE'(b_q >> base);
    end

    carry_skip_block #(
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_csb (
        .a_slice (a_slice),
        .b_slice (b_slice),
        .cin     (carry),
        .s_slice (s_slice),
        .cout    (blk_cout)
    );

`ifdef CSA_EARLY_DONE_EN
    // Nothing left above this slice and no carry to propagate: result is final.
    logic upper_zero;
    always_comb begin
        upper_zero = (((a_q | b_q) >> (base + BLOCK_SIZE)) == '0);
    end
`endif

    always_comb begin
        state_d     = state;
        blk_idx_d   = blk_idx;
        carry_d     = carry;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum;
        cout_d      = cout;
        out_valid_d = out_valid;
        in_ready_d  = in_ready;

        case (state)
            IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    carry_d    = cin;
                    sum_d      = '0;
                    cout_d     = 1'b0;
                    blk_idx_d  = '0;
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b0;
                sum_d       = (sum & ~(SLICE_MASK << base)) | (N'(s_slice) << base);
                carry_d     = blk_cout;
                blk_idx_d   = blk_idx + IDX_W'(1);
                if (blk_idx == LAST_IDX) begin
                    cout_d      = blk_cout;
                    blk_idx_d   = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
`ifdef CSA_EARLY_DONE_EN
                else if (!blk_cout && upper_zero) begin
                    cout_d      = 1'b0;
                    blk_idx_d   = '0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
`endif
            end
            DONE: begin
                in_ready_d  = 1'b0;
                out_valid_d = 1'b1;
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                blk_idx_d   = '0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            blk_idx   <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            state     <= state_d;
            blk_idx   <= blk_idx_d;
            carry     <= carry_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum       <= sum_d;
            cout      <= cout_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_block_serial_csa_adder.sv
// Self-checking bench for block_serial_csa_adder (N=16, BLOCK_SIZE=4); honours CSA_EARLY_DONE_EN.
module tb_block_serial_csa_adder;

    localparam int NW = 16;
    localparam int BS = 4;
    localparam int NB = NW / BS;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [NW-1:0] a = '0;
    logic [NW-1:0] b = '0;
    logic          cin = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [NW-1:0] sum;
    logic          cout;

    int compared   = 0;
    int mismatched = 0;

    block_serial_csa_adder #(.N(NW), .BLOCK_SIZE(BS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Edges from acceptance to result: arithmetic view of the early-completion rule.
    function automatic int lat_of(input logic [NW-1:0] x, input logic [NW-1:0] y, input logic c);
        int r;
        r = NB;
`ifdef CSA_EARLY_DONE_EN
        for (int k = NB - 1; k >= 0; k--) begin
            int hi;
            logic [31:0] msk, low;
            hi  = (k + 1) * BS;
            msk = (32'd1 << hi) - 32'd1;
            low = (32'(x) & msk) + (32'(y) & msk) + 32'(c);
            if (((low >> hi) & 32'd1) == 32'd0 && ((32'(x) | 32'(y)) >> hi) == 32'd0)
                r = k + 1;
        end
`endif
        return r;
    endfunction

    // Transaction-level model: idle / busy for lat edges / holding result.
    int            m_phase = 0;
    int            m_cnt   = 0;
    int            m_lat   = 0;
    logic [NW:0]   m_res   = '0;
    logic          m_ready = 1'b1;
    logic          m_valid = 1'b0;
    logic [NW-1:0] m_sum   = '0;
    logic          m_cout  = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_ready = 1'b1;
            m_valid = 1'b0;
            m_sum   = '0;
            m_cout  = 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_res   = {1'b0, a} + {1'b0, b} + {{NW{1'b0}}, cin};
                    m_lat   = lat_of(a, b, cin);
                    m_cnt   = 0;
                    m_ready = 1'b0;
                    m_phase = 1;
                end
                1: begin
                    m_cnt++;
                    if (m_cnt == m_lat) begin
                        m_valid = 1'b1;
                        m_sum   = m_res[NW-1:0];
                        m_cout  = m_res[NW];
                        m_phase = 2;
                    end
                end
                default: if (out_ready) begin
                    m_valid = 1'b0;
                    m_ready = 1'b1;
                    m_phase = 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 32'(in_ready), 32'(m_ready));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            chk("model_sum", 32'(sum), 32'(m_sum));
            chk("model_cout", 32'(cout), 32'(m_cout));
        end
    end

    task automatic wait_valid(input string nm, output int edges);
        edges = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                edges = i + 1;
                break;
            end
        end
        if (edges < 0) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_txn(input string nm, input logic [NW-1:0] x, input logic [NW-1:0] y, input logic c,
                           input logic [NW-1:0] es, input logic ec, input int el);
        int n;
        @(negedge clk);
        in_valid = 1'b1; a = x; b = y; cin = c; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(nm, n);
        chk({nm, "_lat"}, 32'(n), 32'(el));
        chk({nm, "_sum"}, 32'(sum), 32'(es));
        chk({nm, "_cout"}, 32'(cout), 32'(ec));
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

`ifdef CSA_EARLY_DONE_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    initial begin
        int n1, n2;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        run_txn("ff_plus_1", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, EARLY ? 3 : 4);
        run_txn("all_ones_cin", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 4);
        run_txn("small", 16'h0003, 16'h0001, 1'b0, 16'h0004, 1'b0, EARLY ? 1 : 4);
        run_txn("mixed", 16'h1234, 16'hABCD, 1'b1, 16'hBE02, 1'b0, 4);

        // Result held under backpressure while new operands are offered.
        @(negedge clk);
        in_valid = 1'b1; a = 16'h8000; b = 16'h8000; cin = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 16'h1234; b = 16'h0000;
        wait_valid("msb_carry", n1);
        chk("msb_carry_lat", 32'(n1), 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_sum", 32'(sum), 32'h0000);
            chk("hold_cout", 32'(cout), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;

        // Back-to-back with out_ready held high.
        @(negedge clk);
        in_valid = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 16'h7FFF; b = 16'h0001;
        wait_valid("b2b_first", n1);
        chk("b2b_first_lat", 32'(n1), EARLY ? 32'd1 : 32'd4);
        chk("b2b_first_sum", 32'(sum), 32'h0002);
        wait_valid("b2b_second", n2);
        chk("b2b_gap", 32'(n2), 32'(NB + 2));
        chk("b2b_second_sum", 32'(sum), 32'h8000);
        chk("b2b_second_cout", 32'(cout), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset in the middle of a computation.
        @(negedge clk);
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_sum", 32'(sum), 32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        run_txn("after_rst", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, EARLY ? 1 : 4);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
